// File: rtl/pixel_mem_pkg.sv
// Shared command encodings, FSM states and width helper for the pixel frame store.
package pixel_mem_pkg;

    typedef enum logic [1:0] {
        CMD_NOP   = 2'b00,
        CMD_WRITE = 2'b01,
        CMD_READ  = 2'b10,
        CMD_CLEAR = 2'b11
    } cmd_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WR   = 2'b01,
        RD   = 2'b10,
        CLR  = 2'b11
    } state_e;

    function automatic int data_width(input int ch_width, input int channels);
        return ch_width * channels;
    endfunction

endpackage

// File: rtl/pixel_ram_be.sv
// Single-port synchronous RAM with per-channel write enables and a registered read.
// Read data appears the cycle after an enabled read; the output register holds otherwise.
module pixel_ram_be #(
    parameter int CH_WIDTH   = 8,
    parameter int CHANNELS   = 3,
    parameter int DEPTH      = 262144,
    parameter int ADDR_WIDTH = 18,
    localparam int DATA_WIDTH = CH_WIDTH * CHANNELS
) (
    input  logic                  clk_i,
    input  logic                  en_i,
    input  logic                  we_i,
    input  logic [CHANNELS-1:0]   ch_we_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // No reset here: contents survive reset and the array maps onto block RAM.
    always_ff @(posedge clk_i) begin
        if (en_i) begin
            if (we_i) begin
                for (int i = 0; i < CHANNELS; i++) begin
                    if (ch_we_i[i]) begin
                        mem_q[addr_i][i*CH_WIDTH +: CH_WIDTH] <= wdata_i[i*CH_WIDTH +: CH_WIDTH];
                    end
                end
            end else begin
                rdata_o <= mem_q[addr_i];
            end
        end
    end

endmodule

// File: rtl/pixel_burst_mem.sv
// Pixel frame store with burst WRITE/READ, hardware CLEAR and range-checked requests.
// Read beats arrive 1 cycle after issue; reads stall on RREADY, writes stall on WVALID gaps.
module pixel_burst_mem
    import pixel_mem_pkg::*;
#(
    parameter int CH_WIDTH   = 8,
    parameter int CHANNELS   = 3,
    parameter int DEPTH      = 262144,
    parameter int ADDR_WIDTH = 18,
    parameter int LEN_WIDTH  = 10,
    localparam int DATA_WIDTH = data_width(CH_WIDTH, CHANNELS),
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
    input  logic                  Mem_CLK,
    input  logic                  Mem_RST,
    input  logic                  Mem_REQ_VALID,
    output logic                  Mem_REQ_READY,
    input  logic [1:0]            Mem_CMD,
    input  logic [ADDR_WIDTH-1:0] Mem_ADDR,
    input  logic [LEN_WIDTH-1:0]  Mem_LEN,
    input  logic [CHANNELS-1:0]   Mem_CH_EN,
    input  logic [DATA_WIDTH-1:0] Mem_WDATA,
    input  logic                  Mem_WVALID,
    output logic                  Mem_WREADY,
    output logic [DATA_WIDTH-1:0] Mem_RDATA,
    output logic                  Mem_RVALID,
    input  logic                  Mem_RREADY,
    output logic                  Mem_RLAST,
    output logic                  Mem_BUSY,
    output logic                  Mem_ERR
);

    localparam int AW1 = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_W   = AW1'(DEPTH);
    localparam logic [ADDR_WIDTH:0] LAST_ADDR = AW1'(DEPTH - 1);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [CHANNELS-1:0]   ch_en_q, ch_en_d;
    logic [LEN_WIDTH:0]    beat_q, beat_d;
    logic [ADDR_WIDTH:0]   clr_q, clr_d;
    logic                  rvalid_q, rvalid_d;
    logic                  rlast_q, rlast_d;
    logic                  err_q, err_d;
    logic                  rst_done_q;

    logic                  ram_en, ram_we;
    logic [CHANNELS-1:0]   ram_ch_we;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_wdata, ram_rdata;

    logic                  req_fire, w_fire, r_fire, rd_issue;
    logic                  req_oob, last_beat;
    logic [ADDR_WIDTH:0]   req_end;

    // One extra bit so ADDR+LEN cannot wrap back into range.
    assign req_end   = {1'b0, Mem_ADDR} + AW1'(Mem_LEN);
    assign req_oob   = (req_end >= DEPTH_W);
    assign req_fire  = Mem_REQ_VALID && Mem_REQ_READY;
    assign w_fire    = Mem_WVALID && Mem_WREADY;
    assign r_fire    = rvalid_q && Mem_RREADY;
    assign last_beat = (beat_q == {1'b0, len_q});
    // Issue only when the output register is empty or draining this cycle.
    assign rd_issue  = (state_q == RD) && (beat_q <= {1'b0, len_q}) && (!rvalid_q || Mem_RREADY);

    always_ff @(posedge Mem_CLK or negedge Mem_RST) begin
        if (!Mem_RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req_fire) begin
                    case (Mem_CMD)
                        CMD_WRITE: state_d = req_oob ? IDLE : WR;
                        CMD_READ:  state_d = req_oob ? IDLE : RD;
                        CMD_CLEAR: state_d = CLR;
                        default:   state_d = IDLE;
                    endcase
                end
            end
            WR:      if (w_fire && last_beat) state_d = IDLE;
            RD:      if (r_fire && rlast_q) state_d = IDLE;
            CLR:     if (clr_q == LAST_ADDR) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        Mem_REQ_READY = 1'b0;
        Mem_WREADY    = 1'b0;
        ram_en        = 1'b0;
        ram_we        = 1'b0;
        ram_ch_we     = '0;
        ram_addr      = addr_q;
        ram_wdata     = Mem_WDATA;
        case (state_q)
            IDLE: Mem_REQ_READY = rst_done_q;
            WR: begin
                Mem_WREADY = 1'b1;
                ram_en     = Mem_WVALID;
                ram_we     = 1'b1;
                ram_ch_we  = ch_en_q;
            end
            RD: ram_en = rd_issue;
            CLR: begin
                ram_en    = 1'b1;
                ram_we    = 1'b1;
                ram_ch_we = '1;
                ram_addr  = clr_q[ADDR_WIDTH-1:0];
                ram_wdata = CLEAR_VALUE;
            end
            default: ;
        endcase
    end

    assign Mem_BUSY   = (state_q != IDLE);
    assign Mem_RVALID = rvalid_q;
    assign Mem_RLAST  = rlast_q;
    assign Mem_ERR    = err_q;
    assign Mem_RDATA  = rvalid_q ? ram_rdata : '0;

    always_comb begin
        addr_d   = addr_q;
        len_d    = len_q;
        ch_en_d  = ch_en_q;
        beat_d   = beat_q;
        clr_d    = clr_q;
        rvalid_d = rvalid_q;
        rlast_d  = rlast_q;
        err_d    = req_fire && req_oob && (Mem_CMD == CMD_WRITE || Mem_CMD == CMD_READ);
        if (req_fire) begin
            addr_d  = Mem_ADDR;
            len_d   = Mem_LEN;
            ch_en_d = Mem_CH_EN;
            beat_d  = '0;
            clr_d   = '0;
        end
        if (w_fire || rd_issue) begin
            addr_d = addr_q + 1'b1;
            beat_d = beat_q + 1'b1;
        end
        if (state_q == CLR) begin
            clr_d = clr_q + 1'b1;
        end
        if (rd_issue) begin
            rvalid_d = 1'b1;
            rlast_d  = last_beat;
        end else if (r_fire) begin
            rvalid_d = 1'b0;
            rlast_d  = 1'b0;
        end
    end

    always_ff @(posedge Mem_CLK or negedge Mem_RST) begin
        if (!Mem_RST) begin
            addr_q     <= '0;
            len_q      <= '0;
            ch_en_q    <= '0;
            beat_q     <= '0;
            clr_q      <= '0;
            rvalid_q   <= 1'b0;
            rlast_q    <= 1'b0;
            err_q      <= 1'b0;
            rst_done_q <= 1'b0;
        end else begin
            addr_q     <= addr_d;
            len_q      <= len_d;
            ch_en_q    <= ch_en_d;
            beat_q     <= beat_d;
            clr_q      <= clr_d;
            rvalid_q   <= rvalid_d;
            rlast_q    <= rlast_d;
            err_q      <= err_d;
            rst_done_q <= 1'b1;
        end
    end

    pixel_ram_be #(
        .CH_WIDTH   (CH_WIDTH),
        .CHANNELS   (CHANNELS),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk_i   (Mem_CLK),
        .en_i    (ram_en),
        .we_i    (ram_we),
        .ch_we_i (ram_ch_we),
        .addr_i  (ram_addr),
        .wdata_i (ram_wdata),
        .rdata_o (ram_rdata)
    );

endmodule

// File: tb/tb_pixel_burst_mem.sv
// Directed bench for pixel_burst_mem: full-size instance plus a 16-deep instance for CLEAR.
module tb_pixel_burst_mem;

    localparam logic [1:0] C_NOP = 2'b00, C_WRITE = 2'b01, C_READ = 2'b10, C_CLEAR = 2'b11;

    logic        clk, rst_n;
    logic        req_valid, req_ready, wvalid, wready, rvalid, rready, rlast, busy, err;
    logic [1:0]  cmd;
    logic [17:0] addr;
    logic [9:0]  len;
    logic [2:0]  ch_en;
    logic [23:0] wdata, rdata;

    logic        c_req_valid, c_req_ready, c_wready, c_rvalid, c_rready, c_rlast, c_busy, c_err;
    logic [1:0]  c_cmd;
    logic [3:0]  c_addr;
    logic [9:0]  c_len;
    logic [23:0] c_rdata;

    int checks = 0;
    int errors = 0;

    logic [23:0] wbuf [16];
    logic [23:0] got_dat [16];
    logic        got_last [16];
    int          got_cyc [16];
    int          got_n, hold_viol;

    pixel_burst_mem dut (
        .Mem_CLK(clk), .Mem_RST(rst_n), .Mem_REQ_VALID(req_valid), .Mem_REQ_READY(req_ready),
        .Mem_CMD(cmd), .Mem_ADDR(addr), .Mem_LEN(len), .Mem_CH_EN(ch_en),
        .Mem_WDATA(wdata), .Mem_WVALID(wvalid), .Mem_WREADY(wready),
        .Mem_RDATA(rdata), .Mem_RVALID(rvalid), .Mem_RREADY(rready), .Mem_RLAST(rlast),
        .Mem_BUSY(busy), .Mem_ERR(err)
    );

    pixel_burst_mem #(.DEPTH(16), .ADDR_WIDTH(4), .CLEAR_VALUE(24'h0F0F0F)) dut_c (
        .Mem_CLK(clk), .Mem_RST(rst_n), .Mem_REQ_VALID(c_req_valid), .Mem_REQ_READY(c_req_ready),
        .Mem_CMD(c_cmd), .Mem_ADDR(c_addr), .Mem_LEN(c_len), .Mem_CH_EN(3'b111),
        .Mem_WDATA(24'h0), .Mem_WVALID(1'b0), .Mem_WREADY(c_wready),
        .Mem_RDATA(c_rdata), .Mem_RVALID(c_rvalid), .Mem_RREADY(c_rready), .Mem_RLAST(c_rlast),
        .Mem_BUSY(c_busy), .Mem_ERR(c_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns 1 time unit after the accepting edge.
    task automatic do_req(input logic [1:0] c, input logic [17:0] a, input logic [9:0] l, input logic [2:0] e);
        int w = 0;
        req_valid = 1'b1; cmd = c; addr = a; len = l; ch_en = e;
        while (!req_ready && w < 50) begin tick(); w++; end
        checks++;
        if (!req_ready) begin errors++; $display("FAIL req_accept_timeout ready=%b required=1", req_ready); end
        tick();
        req_valid = 1'b0;
    endtask

    task automatic write_words(input logic [17:0] a, input int n, input logic [2:0] e);
        do_req(C_WRITE, a, 10'(n - 1), e);
        for (int k = 0; k < n; k++) begin
            int w = 0;
            wvalid = 1'b1; wdata = wbuf[k];
            while (!wready && w < 20) begin tick(); w++; end
            tick();
        end
        wvalid = 1'b0;
    endtask

    // RREADY is high on cycles where cyc % period == 0; records handshaken beats.
    task automatic collect(input int nbeats, input int period);
        logic [23:0] pd;
        logic        pl, pv;
        got_n = 0; hold_viol = 0; pv = 1'b0; pd = '0; pl = 1'b0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            rready = ((cyc % period) == 0);
            if (pv && !(rvalid && rdata == pd && rlast == pl)) hold_viol++;
            pv = 1'b0;
            if (rvalid) begin
                if (rready) begin
                    if (got_n < 16) begin got_dat[got_n] = rdata; got_last[got_n] = rlast; got_cyc[got_n] = cyc; end
                    got_n++;
                end else begin
                    pv = 1'b1; pd = rdata; pl = rlast;
                end
            end
            tick();
            if (got_n >= nbeats) break;
        end
        rready = 1'b1;
        for (int j = 0; j < 3; j++) begin
            if (rvalid) got_n++;
            tick();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = 0; cmd = C_NOP; addr = '0; len = '0; ch_en = '0; wdata = '0; wvalid = 0; rready = 0;
        c_req_valid = 0; c_cmd = C_NOP; c_addr = '0; c_len = '0; c_rready = 0;
        repeat (3) tick();
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_req_ready got %b required 0", req_ready); end
        checks++; if (wready !== 1'b0) begin errors++; $display("FAIL rst_wready got %b required 0", wready); end
        checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL rst_rvalid got %b required 0", rvalid); end
        checks++; if (rlast !== 1'b0) begin errors++; $display("FAIL rst_rlast got %b required 0", rlast); end
        checks++; if (rdata !== 24'h0) begin errors++; $display("FAIL rst_rdata got %h required 000000", rdata); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b required 0", busy); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err got %b required 0", err); end
        rst_n = 1'b1;
        tick();
        wbuf[0] = 24'hAABBCC;
        write_words(18'd5, 1, 3'b111);
        tick();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_read_after_reset();
        rready = 1'b1;
        do_req(C_READ, 18'd5, 10'd0, 3'b000);
        checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL rd1_rvalid_at_issue got %b required 0", rvalid); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rd1_busy got %b required 1", busy); end
        tick();
        checks++; if (rvalid !== 1'b1) begin errors++; $display("FAIL rd1_rvalid got %b required 1", rvalid); end
        checks++; if (rdata !== 24'hAABBCC) begin errors++; $display("FAIL rd1_retained_data got %h required aabbcc", rdata); end
        checks++; if (rlast !== 1'b1) begin errors++; $display("FAIL rd1_rlast got %b required 1", rlast); end
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rd1_busy_after got %b required 0", busy); end
        checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL rd1_rvalid_after got %b required 0", rvalid); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rd1_req_ready got %b required 1", req_ready); end
    endtask

    task automatic test_write_gap_burst();
        logic [23:0] exp;
        do_req(C_WRITE, 18'd100, 10'd3, 3'b111);
        for (int k = 0; k < 4; k++) begin
            if (k == 2) begin
                wvalid = 1'b0;
                tick(); tick();
                checks++; if (busy !== 1'b1 || wready !== 1'b1) begin errors++; $display("FAIL wr_gap_stall busy=%b wready=%b required 1 1", busy, wready); end
            end
            wvalid = 1'b1; wdata = {3{8'(k + 1)}};
            checks++; if (wready !== 1'b1) begin errors++; $display("FAIL wr_beat%0d_wready got %b required 1", k, wready); end
            tick();
        end
        wvalid = 1'b0;
        checks++; if (busy !== 1'b0 || wready !== 1'b0) begin errors++; $display("FAIL wr_done busy=%b wready=%b required 0 0", busy, wready); end
        do_req(C_READ, 18'd100, 10'd3, 3'b000);
        collect(4, 1);
        checks++; if (got_n !== 4) begin errors++; $display("FAIL rd4_beats got %0d required 4", got_n); end
        checks++; if (got_cyc[0] !== 1) begin errors++; $display("FAIL rd4_first_latency got %0d required 1", got_cyc[0]); end
        for (int k = 0; k < 4 && k < got_n; k++) begin
            exp = {3{8'(k + 1)}};
            checks++; if (got_dat[k] !== exp) begin errors++; $display("FAIL rd4_data%0d got %h required %h", k, got_dat[k], exp); end
            checks++; if (got_last[k] !== (k == 3)) begin errors++; $display("FAIL rd4_rlast%0d got %b required %b", k, got_last[k], k == 3); end
            checks++; if (got_cyc[k] !== got_cyc[0] + k) begin errors++; $display("FAIL rd4_b2b%0d got cycle %0d required %0d", k, got_cyc[k], got_cyc[0] + k); end
        end
    endtask

    task automatic test_ch_enable();
        wbuf[0] = 24'h112233;
        write_words(18'd7, 1, 3'b111);
        wbuf[0] = 24'hFFFFFF;
        write_words(18'd7, 1, 3'b010);
        do_req(C_READ, 18'd7, 10'd0, 3'b000);
        collect(1, 1);
        checks++; if (got_n !== 1) begin errors++; $display("FAIL chen_beats got %0d required 1", got_n); end
        checks++; if (got_dat[0] !== 24'h11FF33) begin errors++; $display("FAIL chen_data got %h required 11ff33", got_dat[0]); end
    endtask

    task automatic test_range();
        int bad = 0;
        do_req(C_READ, 18'd262140, 10'd3, 3'b000);
        checks++; if (err !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL range_top_accept err=%b busy=%b required 0 1", err, busy); end
        collect(4, 1);
        checks++; if (got_n !== 4) begin errors++; $display("FAIL range_top_beats got %0d required 4", got_n); end
        checks++; if (got_last[3] !== 1'b1 || got_last[0] !== 1'b0) begin errors++; $display("FAIL range_top_rlast got %b%b required 01", got_last[0], got_last[3]); end
        do_req(C_READ, 18'd262141, 10'd3, 3'b000);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL range_rej_err got %b required 1", err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL range_rej_busy got %b required 0", busy); end
        tick();
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL range_rej_err_width got %b required 0", err); end
        for (int j = 0; j < 3; j++) begin
            if (rvalid || busy) bad++;
            tick();
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL range_rej_quiet got %0d active cycles required 0", bad); end
        do_req(C_WRITE, 18'd262143, 10'd1, 3'b111);
        checks++; if (err !== 1'b1 || wready !== 1'b0) begin errors++; $display("FAIL range_wr_rej err=%b wready=%b required 1 0", err, wready); end
        do_req(C_NOP, 18'd262143, 10'd1023, 3'b000);
        checks++; if (err !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL nop err=%b busy=%b required 0 0", err, busy); end
        tick();
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL nop_err_late got %b required 0", err); end
    endtask

    task automatic test_read_stall();
        logic [23:0] exp;
        for (int k = 0; k < 8; k++) wbuf[k] = {8'(k), 8'(k * 3), 8'(8'hA0 + 8'(k))};
        write_words(18'd0, 8, 3'b111);
        do_req(C_READ, 18'd0, 10'd7, 3'b000);
        collect(8, 3);
        checks++; if (got_n !== 8) begin errors++; $display("FAIL stall_beats got %0d required 8", got_n); end
        checks++; if (hold_viol !== 0) begin errors++; $display("FAIL stall_hold got %0d changes required 0", hold_viol); end
        for (int k = 0; k < 8 && k < got_n; k++) begin
            exp = {8'(k), 8'(k * 3), 8'(8'hA0 + 8'(k))};
            checks++; if (got_dat[k] !== exp) begin errors++; $display("FAIL stall_data%0d got %h required %h", k, got_dat[k], exp); end
            checks++; if (got_last[k] !== (k == 7)) begin errors++; $display("FAIL stall_rlast%0d got %b required %b", k, got_last[k], k == 7); end
        end
    endtask

    task automatic test_clear();
        int w = 0, busy_cnt = 0, n = 0, bad = 0;
        c_req_valid = 1'b1; c_cmd = C_CLEAR; c_addr = '0; c_len = '0;
        while (!c_req_ready && w < 50) begin tick(); w++; end
        tick();
        c_req_valid = 1'b0;
        while (c_busy && busy_cnt < 100) begin busy_cnt++; tick(); end
        checks++; if (busy_cnt !== 16) begin errors++; $display("FAIL clr_busy_cycles got %0d required 16", busy_cnt); end
        c_rready = 1'b1;
        c_req_valid = 1'b1; c_cmd = C_READ; c_addr = 4'd0; c_len = 10'd15;
        w = 0;
        while (!c_req_ready && w < 50) begin tick(); w++; end
        tick();
        c_req_valid = 1'b0;
        for (int cyc = 0; cyc < 60 && n < 16; cyc++) begin
            if (c_rvalid) begin
                if (c_rdata !== 24'h0F0F0F) bad++;
                n++;
            end
            tick();
        end
        checks++; if (n !== 16) begin errors++; $display("FAIL clr_read_beats got %0d required 16", n); end
        checks++; if (bad !== 0) begin errors++; $display("FAIL clr_data got %0d wrong words required 0", bad); end
    endtask

    task automatic test_reset_mid_write();
        logic [23:0] exp;
        wbuf[0] = 24'h777777;
        write_words(18'd203, 1, 3'b111);
        do_req(C_WRITE, 18'd200, 10'd9, 3'b111);
        for (int k = 0; k < 3; k++) begin
            wvalid = 1'b1; wdata = 24'h500000 + 24'(k);
            tick();
        end
        wdata = 24'h500003;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || wready !== 1'b0) begin errors++; $display("FAIL midrst_idle busy=%b wready=%b required 0 0", busy, wready); end
        checks++; if (req_ready !== 1'b0 || rvalid !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL midrst_outputs req_ready=%b rvalid=%b err=%b required 0 0 0", req_ready, rvalid, err); end
        wvalid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        do_req(C_READ, 18'd200, 10'd3, 3'b000);
        collect(4, 1);
        checks++; if (got_n !== 4) begin errors++; $display("FAIL midrst_beats got %0d required 4", got_n); end
        for (int k = 0; k < 4 && k < got_n; k++) begin
            exp = (k < 3) ? 24'h500000 + 24'(k) : 24'h777777;
            checks++; if (got_dat[k] !== exp) begin errors++; $display("FAIL midrst_data%0d got %h required %h", k, got_dat[k], exp); end
        end
    endtask

    initial begin
        test_reset();
        test_read_after_reset();
        test_write_gap_burst();
        test_ch_enable();
        test_range();
        test_read_stall();
        test_clear();
        test_reset_mid_write();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired after %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
